// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
  } div_result_t;

endpackage

// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module cla_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum_c,
  output logic        cout_c
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic        carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    carry = cin;
    sum_c = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    for (int grp = 0; grp < 8; grp++) begin
      grp_g    = gen[grp*4 +: 4];
      grp_p    = prop[grp*4 +: 4];
      grp_c[0] = carry;
      grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (&grp_p[1:0] & grp_c[0]);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (&grp_p[2:1] & grp_g[0])
               | (&grp_p[2:0] & grp_c[0]);
      grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (&grp_p[3:2] & grp_g[1])
               | (&grp_p[3:1] & grp_g[0]) | (&grp_p & grp_c[0]);
      sum_c[grp*4 +: 4] = grp_p ^ grp_c[3:0];
      carry = grp_c[4];
    end
    cout_c = carry;
  end

endmodule

// File: rtl/neg_abs_32.sv
// Conditional two's-complement negate; used for operand magnitudes and sign fix-up.
module neg_abs_32 (
  input  logic [31:0] value,
  input  logic        negate,
  output logic [31:0] result_c
);

  assign result_c = negate ? (~value + 32'd1) : value;

endmodule

// File: rtl/seq_divider_32.sv
// Iterative 32-bit restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional early exit on zero divisor when DIV_ZERO_CHECK_EN is defined.
module seq_divider_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  quo_sr_q, quo_sr_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  div_result_t       res_q, res_d;

  logic              is_idle_c;
  logic              accept_c;
  logic              dz_hit_c;
  logic [WIDTH-1:0]  shifted_c;
  logic [WIDTH-1:0]  trial_c;
  logic              carry_c;
  logic [WIDTH-1:0]  mag_a_c;
  logic [WIDTH-1:0]  mag_b_c;

  assign is_idle_c = (state_q == IDLE);
  // A start coinciding with the done pulse is dropped.
  assign accept_c  = is_idle_c && start && !done_q;

`ifdef DIV_ZERO_CHECK_EN
  assign dz_hit_c = (divisor == '0);
`else
  assign dz_hit_c = 1'b0;
`endif

  // Shared negators: operand magnitudes in IDLE, sign correction in FIX.
  neg_abs_32 u_neg_a (
    .value    (is_idle_c ? dividend : quo_sr_q),
    .negate   (is_idle_c ? (signed_op & dividend[WIDTH-1]) : quo_neg_q),
    .result_c (mag_a_c)
  );

  neg_abs_32 u_neg_b (
    .value    (is_idle_c ? divisor : rem_q),
    .negate   (is_idle_c ? (signed_op & divisor[WIDTH-1]) : rem_neg_q),
    .result_c (mag_b_c)
  );

  // Partial remainder never exceeds 32 bits, so the adder carry alone signals no-borrow.
  assign shifted_c = {rem_q[WIDTH-2:0], quo_sr_q[WIDTH-1]};

  cla_adder_32 u_add (
    .a      (shifted_c),
    .b      (~dvsr_q),
    .cin    (1'b1),
    .sum_c  (trial_c),
    .cout_c (carry_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_sr_d  = quo_sr_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    dbz_d     = dbz_q;
    res_d     = res_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          dbz_d  = 1'b0;
          cnt_d  = CNT_W'(ITER_COUNT - 1);
          dvsr_d = mag_b_c;
          if (dz_hit_c) begin
            quo_sr_d  = '1;
            rem_d     = dividend;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            dz_d      = 1'b1;
            state_d   = FIX;
          end else begin
            quo_sr_d  = mag_a_c;
            rem_d     = '0;
            quo_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rem_neg_d = signed_op & dividend[WIDTH-1];
            dz_d      = 1'b0;
            state_d   = ITER;
          end
        end
      end
      ITER: begin
        quo_sr_d = {quo_sr_q[WIDTH-2:0], carry_c};
        rem_d    = carry_c ? trial_c : shifted_c;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        res_d.quotient  = mag_a_c;
        res_d.remainder = mag_b_c;
        dbz_d           = dz_q;
        done_d          = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_sr_q  <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_sr_q  <= quo_sr_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      res_q     <= res_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = res_q.quotient;
  assign remainder   = res_q.remainder;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32; expectations adapt to DIV_ZERO_CHECK_EN.
module tb_seq_divider_32;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  seq_divider_32 dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns in the done cycle (or on timeout with lat=-1).
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output int busy_n);
    start     = 1'b1;
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    q = '0; r = '0; dz = 1'b0; lat = -1;
    @(posedge clock); #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    busy_n   = int'(busy);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = n + 1;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        break;
      end
      busy_n += int'(busy);
      if (n == inject_at) begin
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd200;
        divisor   = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] got_q, got_r;
    logic        got_dz;
    int          got_lat, got_busy;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,       32'd14,      32'd2,       1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,       32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
    vecs[2]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,       1'b0, 34};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,  32'd2,       32'h7FFFFFFF, 32'd1,       1'b0, 34};
    vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,      1'b0, 34};
`ifdef DIV_ZERO_CHECK_EN
    vecs[5]  = '{1'b0, 32'h55,        32'd0,       32'hFFFFFFFF, 32'h55,      1'b1, 2};
    vecs[6]  = '{1'b1, 32'hFFFFFFAB,  32'd0,       32'hFFFFFFFF, 32'hFFFFFFAB, 1'b1, 2};
`else
    vecs[5]  = '{1'b0, 32'h55,        32'd0,       32'hFFFFFFFF, 32'h55,      1'b0, 34};
    vecs[6]  = '{1'b1, 32'hFFFFFFAB,  32'd0,       32'd1,       32'hFFFFFFAB, 1'b0, 34};
`endif
    vecs[7]  = '{1'b0, 32'd0,         32'd5,       32'd0,       32'd0,       1'b0, 34};
    vecs[8]  = '{1'b0, 32'd7,         32'd7,       32'd1,       32'd0,       1'b0, 34};
    vecs[9]  = '{1'b0, 32'd5,         32'd9,       32'd0,       32'd5,       1'b0, 34};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,      32'hFFFFFFFF, 1'b0, 34};
    vecs[11] = '{1'b0, 32'h499602D2,  32'h3039,    32'h186A5,   32'h1815,    1'b0, 34};
    vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,      32'd0,       1'b0, 34};
    vecs[13] = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,      32'h80000000, 1'b0, 34};

    reset_n   = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy",        32'(busy),        32'd0);
    check("reset done",        32'(done),        32'd0);
    check("reset quotient",    quotient,         32'd0);
    check("reset remainder",   remainder,        32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].sg, vecs[i].a, vecs[i].b, -1, got_q, got_r, got_dz, got_lat, got_busy);
      check($sformatf("v%0d latency", i),     32'(got_lat),  32'(vecs[i].lat));
      check($sformatf("v%0d quotient", i),    got_q,         vecs[i].q);
      check($sformatf("v%0d remainder", i),   got_r,         vecs[i].r);
      check($sformatf("v%0d div_by_zero", i), 32'(got_dz),   32'(vecs[i].dz));
      check($sformatf("v%0d busy cycles", i), 32'(got_busy), 32'(vecs[i].lat - 1));
      // A start presented during the done cycle must be dropped.
      start     = 1'b1;
      signed_op = 1'b0;
      dividend  = 32'h1234;
      divisor   = 32'h5;
      @(posedge clock); #1;
      start = 1'b0;
      check($sformatf("v%0d busy after done", i), 32'(busy), 32'd0);
      check($sformatf("v%0d done pulse width", i), 32'(done), 32'd0);
      check($sformatf("v%0d quotient hold", i), quotient, vecs[i].q);
      check($sformatf("v%0d remainder hold", i), remainder, vecs[i].r);
    end

    // Start pulsed mid-operation is ignored.
    run_op(1'b0, 32'd100, 32'd7, 10, got_q, got_r, got_dz, got_lat, got_busy);
    check("midstart latency",   32'(got_lat),  32'd34);
    check("midstart quotient",  got_q,         32'd14);
    check("midstart remainder", got_r,         32'd2);
    check("midstart busy",      32'(got_busy), 32'd33);
    @(posedge clock); #1;
    check("midstart no restart", 32'(busy), 32'd0);

    // Reset in the middle of an operation aborts with no done pulse.
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort busy",        32'(busy),        32'd0);
    check("abort done",        32'(done),        32'd0);
    check("abort quotient",    quotient,         32'd0);
    check("abort remainder",   remainder,        32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (done || busy) begin
        check("abort no done after reset", 32'(done | busy), 32'd0);
        break;
      end
    end
    run_op(1'b0, 32'd10, 32'd3, -1, got_q, got_r, got_dz, got_lat, got_busy);
    check("post-reset latency",   32'(got_lat), 32'd34);
    check("post-reset quotient",  got_q,        32'd3);
    check("post-reset remainder", got_r,        32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
